// File: rtl/cla_seq_ctrl.sv
// rtl/cla_seq_ctrl.sv - multi-word add sequencer driving one external W-bit CLA slice, LSW first
// Optional subtract mode (extra sub input) is enabled by defining CLA_SEQ_SUB_EN.
module cla_seq_ctrl #(
  parameter int W     = 16,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef CLA_SEQ_SUB_EN
  input  logic               sub,
`endif
  input  logic [W*WORDS-1:0] a,
  input  logic [W*WORDS-1:0] b,
  input  logic               cin,
  output logic               busy,
  output logic               done,
  output logic [W*WORDS-1:0] s,
  output logic               cout,
  output logic [W-1:0]       add_a,
  output logic [W-1:0]       add_b,
  output logic               add_cin,
  input  logic [W-1:0]       add_s,
  input  logic               add_cout
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, next_state;

  logic [WORDS-1:0][W-1:0] a_r, b_r, s_r;
  logic [IW-1:0]           idx;
  logic                    carry;
  logic                    cout_r;
  logic                    accept;
  logic                    last;

  // A new request can only be taken when no slice walk is in flight.
  assign accept = start && (state != RUN);
  assign last   = (idx == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last)  next_state = DONE;
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      s_r    <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
    end else if (accept) begin
      a_r   <= a;
`ifdef CLA_SEQ_SUB_EN
      // Subtract as a + ~b + 1; the forced carry-in replaces cin.
      b_r   <= sub ? ~b : b;
      carry <= sub | cin;
`else
      b_r   <= b;
      carry <= cin;
`endif
      idx   <= '0;
    end else if (state == RUN) begin
      s_r[idx] <= add_s;
      carry    <= add_cout;
      idx      <= last ? '0 : idx + IW'(1);
      if (last) cout_r <= add_cout;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign s    = s_r;
  assign cout = cout_r;

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_r[idx];
      add_b   = b_r[idx];
      add_cin = carry;
    end
  end

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// tb/tb_cla_seq_ctrl.sv - self-checking bench for cla_seq_ctrl with a behavioural CLA and result model
// Exercises subtract mode as well when CLA_SEQ_SUB_EN is defined.
module tb_cla_seq_ctrl;
  localparam int W     = 16;
  localparam int WORDS = 4;
  localparam int N     = W * WORDS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
`ifdef CLA_SEQ_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         busy, done, cout, add_cin, add_cout;
  logic [N-1:0] s;
  logic [W-1:0] add_a, add_b, add_s;

  int checks = 0;
  int failures = 0;

  cla_seq_ctrl #(.W(W), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef CLA_SEQ_SUB_EN
    .sub(sub),
`endif
    .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .s(s), .cout(cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout)
  );

  // External CLA slice
  assign {add_cout, add_s} = 17'(add_a) + 17'(add_b) + 17'(add_cin);

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: one operation = full-width sum of the operands captured at the accept edge
  int           edge_n = 0;
  bit           m_active = 0;
  int           m_acc = 0;
  logic [N-1:0] m_a, m_b;
  logic         m_cin;
  logic [64:0]  m_res;
  logic [W-1:0] a_log[$];
  logic         cin_log[$];

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0;
    end else if (start && (!m_active || edge_n >= m_acc + WORDS + 1)) begin
      m_active = 1;
      m_acc    = edge_n;
      m_a      = a;
`ifdef CLA_SEQ_SUB_EN
      m_b   = sub ? ~b : b;
      m_cin = sub ? 1'b1 : cin;
`else
      m_b   = b;
      m_cin = cin;
`endif
      m_res = {1'b0, m_a} + {1'b0, m_b} + 65'(m_cin);
    end
  end

  function automatic logic carry_into(input int j);
    logic [64:0] mask, sum;
    mask = (65'd1 << (j * W)) - 65'd1;
    sum  = ({1'b0, m_a} & mask) + ({1'b0, m_b} & mask) + 65'(m_cin);
    return sum[j * W];
  endfunction

  always @(posedge clk) begin
    int  le, j;
    bit  exp_busy, exp_done;
    #3;
    le       = edge_n - 1;
    exp_busy = m_active && le >= m_acc && le < m_acc + WORDS;
    exp_done = m_active && le == m_acc + WORDS;
    chk("busy", 65'(busy), 65'(exp_busy));
    chk("done", 65'(done), 65'(exp_done));
    if (exp_busy) begin
      j = le - m_acc;
      chk("add_a", 65'(add_a), 65'((m_a >> (j * W)) & 64'hFFFF));
      chk("add_b", 65'(add_b), 65'((m_b >> (j * W)) & 64'hFFFF));
      chk("add_cin", 65'(add_cin), 65'(carry_into(j)));
      a_log.push_back(add_a);
      cin_log.push_back(add_cin);
    end else begin
      chk("add_idle", {47'd0, add_a, add_b, add_cin}, 65'd0);
    end
    if (!m_active) chk("s_cout_clear", {cout, s}, 65'd0);
    else if (le >= m_acc + WORDS) chk("s_cout", {cout, s}, m_res);
  end

  task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tc,
                        input logic tsub, output int lat, output int busy_cnt);
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1'b1;
`ifdef CLA_SEQ_SUB_EN
    sub = tsub;
`endif
    a_log.delete();
    cin_log.delete();
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (!done) chk("done_timeout", 65'(done), 65'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc, nd;
    logic [64:0] dres[$];
    logic [3:0] cv;

    repeat (2) @(negedge clk);
    chk("reset_outputs", {cout, s}, 65'd0);
    chk("reset_flags", {62'd0, busy, done, add_cin}, 65'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: carry out of the low slice
    run_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, lat, bc);
    chk("t1_sum", {cout, s}, {1'b0, 64'h0000_0000_0001_0000});
    chk("t1_latency", 65'(lat), 65'd4);
    chk("t1_busy_cycles", 65'(bc), 65'd4);
    @(negedge clk);
    chk("t1_done_single", 65'(done), 65'd0);

    // 2: carry ripples through every slice
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, lat, bc);
    chk("t2_sum", {cout, s}, {1'b1, 64'd0});
    chk("t2_cin_count", 65'(cin_log.size()), 65'd4);
    cv = '0;
    foreach (cin_log[i]) if (i < 4) cv[i] = cin_log[i];
    chk("t2_cin_all", 65'(cv), 65'hF);
    repeat (2) @(negedge clk);

    // 3: slice order LSW first
    run_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0, lat, bc);
    chk("t3_sum", {cout, s}, {1'b0, 64'h2345_6789_ABCD_F001});
    chk("t3_alog_size", 65'(a_log.size()), 65'd4);
    if (a_log.size() == 4) begin
      chk("t3_alog0", 65'(a_log[0]), 65'h DEF0);
      chk("t3_alog1", 65'(a_log[1]), 65'h9ABC);
      chk("t3_alog2", 65'(a_log[2]), 65'h5678);
      chk("t3_alog3", 65'(a_log[3]), 65'h1234);
    end
    repeat (2) @(negedge clk);

    // 4: start held for 12 cycles, operands changing each cycle
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (done) dres.push_back({cout, s});
      if (i < 12) begin
        start = 1'b1;
        a = 64'(i) * 64'h0001_0001_0001_0001;
        b = 64'hFFFF_FFFF_FFFF_FFFF;
        cin = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk("t4_done_count", 65'(dres.size()), 65'd3);
    if (dres.size() == 3) begin
      chk("t4_res0", dres[0], {1'b1, 64'd0});
      chk("t4_res1", dres[1], {1'b1, 64'h0005_0005_0005_0005});
      chk("t4_res2", dres[2], {1'b1, 64'h000A_000A_000A_000A});
    end

    // 5: reset in the middle of a run
    @(negedge clk);
    a = 64'h1234; b = 64'h4321; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_busy", 65'(busy), 65'd0);
    chk("t5_done", 65'(done), 65'd0);
    chk("t5_s_cout", {cout, s}, 65'd0);
    chk("t5_add", {47'd0, add_a, add_b, add_cin}, 65'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("t5_no_done", 65'(nd), 65'd0);
    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, lat, bc);
    chk("t5_after_sum", {cout, s}, {1'b1, 64'd1});

`ifdef CLA_SEQ_SUB_EN
    // 6: subtract mode
    repeat (2) @(negedge clk);
    run_op(64'd5, 64'd7, 1'b0, 1'b1, lat, bc);
    chk("t6_sub_neg", {cout, s}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
    repeat (2) @(negedge clk);
    run_op(64'd7, 64'd5, 1'b0, 1'b1, lat, bc);
    chk("t6_sub_pos", {cout, s}, {1'b1, 64'd2});
    sub = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
